level_sensor_filter: RTL and testbench



---
 rtl/level_sensor_filter.sv | 141 ++++++++++++++
 tb/tb_level_sensor_filter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/level_sensor_filter.sv
// level_sensor_filter
// Conditions the two raw tank level sensors for the tank controller.
// Each raw line is synchronised through two flops and then debounced.
// The clean levels are presented on I and S. A sustained implausible
// combination (upper wet, lower dry) latches a fault.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   I_raw      raw lower sensor (async), 1 = water present
//   S_raw      raw upper sensor (async), 1 = water present
//   fault_clr  single-cycle request to clear a latched fault
//   I          filtered lower sensor
//   S          filtered upper sensor
//   fault      latched plausibility fault
//   valid      high once the filters have settled after reset
//
// Reset drives I=S=1 (FULL), so downstream pumps stay off.

module level_sensor_filter #(
  parameter int DEBOUNCE     = 4,
  parameter int FAULT_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic I_raw,
  input  logic S_raw,
  input  logic fault_clr,
  output logic I,
  output logic S,
  output logic fault,
  output logic valid
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] FLT_TC = CNT_W'(FAULT_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             i_sync1_q, i_sync1_d, i_sync2_q, i_sync2_d;
  logic             s_sync1_q, s_sync1_d, s_sync2_q, s_sync2_d;
  logic             i_filt_q, i_filt_d, s_filt_q, s_filt_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d, s_cnt_q, s_cnt_d;
  logic [CNT_W-1:0] i_cnt_inc, s_cnt_inc;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d, flt_cnt_inc;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] vld_cnt_q, vld_cnt_d;
  logic             settled_q, settled_d;
  logic             valid_q, valid_d;
  logic             implausible;

  always_comb begin
    i_sync1_d = I_raw;
    i_sync2_d = i_sync1_q;
    s_sync1_d = S_raw;
    s_sync2_d = s_sync1_q;

    // Debounce: count cycles where sync2 disagrees with the filtered
    // value; a single agreeing cycle restarts the count.
    i_cnt_inc = i_cnt_q + ONE;
    i_filt_d  = i_filt_q;
    i_cnt_d   = '0;
    if (i_sync2_q != i_filt_q) begin
      if (i_cnt_inc == DEB_TC) begin
        i_filt_d = i_sync2_q;
      end else begin
        i_cnt_d = i_cnt_inc;
      end
    end

    s_cnt_inc = s_cnt_q + ONE;
    s_filt_d  = s_filt_q;
    s_cnt_d   = '0;
    if (s_sync2_q != s_filt_q) begin
      if (s_cnt_inc == DEB_TC) begin
        s_filt_d = s_sync2_q;
      end else begin
        s_cnt_d = s_cnt_inc;
      end
    end

    // Plausibility runs on the filtered levels, so raw glitches
    // cannot trip it.
    implausible = s_filt_q & ~i_filt_q;
    flt_cnt_inc = flt_cnt_q + ONE;
    flt_cnt_d   = '0;
    fault_d     = fault_q;
    if (fault_clr) begin
      // Clear wins over a coincident set.
      flt_cnt_d = '0;
      fault_d   = 1'b0;
    end else if (implausible) begin
      flt_cnt_d = (flt_cnt_q == FLT_TC) ? flt_cnt_q : flt_cnt_inc;
      fault_d   = fault_q | (flt_cnt_d == FLT_TC);
    end

    // Valid counter saturates at DEBOUNCE; one extra stage gives the
    // DEBOUNCE+2 edge delay without needing a wider counter.
    vld_cnt_d = (vld_cnt_q == DEB_TC) ? vld_cnt_q : (vld_cnt_q + ONE);
    settled_d = settled_q | (vld_cnt_q == DEB_TC);
    valid_d   = settled_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_sync1_q <= 1'b1;
      i_sync2_q <= 1'b1;
      s_sync1_q <= 1'b1;
      s_sync2_q <= 1'b1;
      i_filt_q  <= 1'b1;
      s_filt_q  <= 1'b1;
      i_cnt_q   <= '0;
      s_cnt_q   <= '0;
      flt_cnt_q <= '0;
      fault_q   <= 1'b0;
      vld_cnt_q <= '0;
      settled_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      i_sync1_q <= i_sync1_d;
      i_sync2_q <= i_sync2_d;
      s_sync1_q <= s_sync1_d;
      s_sync2_q <= s_sync2_d;
      i_filt_q  <= i_filt_d;
      s_filt_q  <= s_filt_d;
      i_cnt_q   <= i_cnt_d;
      s_cnt_q   <= s_cnt_d;
      flt_cnt_q <= flt_cnt_d;
      fault_q   <= fault_d;
      vld_cnt_q <= vld_cnt_d;
      settled_q <= settled_d;
      valid_q   <= valid_d;
    end
  end

  assign I     = i_filt_q;
  assign S     = s_filt_q;
  assign fault = fault_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_level_sensor_filter.sv
module tb_level_sensor_filter;

  localparam int DEB = 4;
  localparam int FC  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic I_raw = 1'b1;
  logic S_raw = 1'b1;
  logic fault_clr = 1'b0;
  logic I, S, fault, valid;

  int nerr = 0;
  int nchk = 0;

  level_sensor_filter #(.DEBOUNCE(DEB), .FAULT_CYCLES(FC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .I_raw(I_raw), .S_raw(S_raw),
    .fault_clr(fault_clr), .I(I), .S(S), .fault(fault), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the filtered value changes when the last DEB
  // synchronised samples all disagree with it; fault is set once the
  // implausible level pair has been seen on FC consecutive edges since
  // it began or since the last clear.
  bit m_s1_i, m_s2_i, m_i, m_s1_s, m_s2_s, m_s;
  bit hist_i[$];
  bit hist_s[$];
  int run;
  int edges;
  bit m_fault, m_valid;
  bit cond, flip;

  function automatic void model_reset();
    m_s1_i = 1; m_s2_i = 1; m_i = 1;
    m_s1_s = 1; m_s2_s = 1; m_s = 1;
    hist_i.delete(); hist_s.delete();
    run = 0; edges = 0; m_fault = 0; m_valid = 0;
  endfunction

  initial model_reset();

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      cond = m_s && !m_i;

      hist_i.push_back(m_s2_i);
      if (hist_i.size() > DEB) void'(hist_i.pop_front());
      flip = (hist_i.size() == DEB);
      foreach (hist_i[j]) if (hist_i[j] == m_i) flip = 0;
      if (flip) begin m_i = !m_i; hist_i.delete(); end

      hist_s.push_back(m_s2_s);
      if (hist_s.size() > DEB) void'(hist_s.pop_front());
      flip = (hist_s.size() == DEB);
      foreach (hist_s[j]) if (hist_s[j] == m_s) flip = 0;
      if (flip) begin m_s = !m_s; hist_s.delete(); end

      m_s2_i = m_s1_i; m_s1_i = I_raw;
      m_s2_s = m_s1_s; m_s1_s = S_raw;

      if (fault_clr) begin
        run = 0; m_fault = 0;
      end else if (cond) begin
        run++;
        if (run == FC) m_fault = 1;
      end else begin
        run = 0;
      end

      edges++;
      m_valid = (edges >= DEB + 2);
    end
  end

  always @(negedge clk) begin
    chk("model_I", I, m_i);
    chk("model_S", S, m_s);
    chk("model_fault", fault, m_fault);
    chk("model_valid", valid, m_valid);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hold_i, hold_s;

  initial begin
    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_I", I, 1'b1);
    chk("rst_S", S, 1'b1);
    chk("rst_fault", fault, 1'b0);
    chk("rst_valid", valid, 1'b0);
    @(negedge clk) reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("idle_valid", valid, (e >= 6));
      chk("idle_I", I, 1'b1);
      chk("idle_S", S, 1'b1);
      chk("idle_fault", fault, 1'b0);
    end

    // Clean transition on I; S stays 1, so the fault path starts counting
    @(negedge clk) I_raw = 1'b0;
    tick();
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("clean_I", I, (e >= 5) ? 1'b0 : 1'b1);
      chk("clean_S", S, 1'b1);
    end
    for (int e = 6; e <= 13; e++) begin
      tick();
      chk("fault_set", fault, (e >= 13));
    end
    I_raw = 1'b1;
    repeat (10) tick();
    chk("fault_latched", fault, 1'b1);
    chk("restored_I", I, 1'b1);

    // Clear with the condition gone
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_gone", fault, 1'b0);
    repeat (10) tick();
    chk("clr_gone_stay", fault, 1'b0);

    // Glitch rejection on I (S parked at 0 so no fault)
    S_raw = 1'b0;
    repeat (8) tick();
    chk("glitch_S_low", S, 1'b0);
    I_raw = 1'b0;
    repeat (3) tick();
    I_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("glitch3_I", I, 1'b1);
    end
    I_raw = 1'b0;
    tick();
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("pulse4_I", I, (e >= 5) ? 1'b0 : 1'b1);
      if (e == 3) I_raw = 1'b1;
    end
    repeat (6) tick();
    chk("pulse4_back", I, 1'b1);

    // Simultaneous change into the implausible state, clear while persisting
    I_raw = 1'b0;
    S_raw = 1'b1;
    tick();
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (e == 4) begin
        chk("simul_I_hold", I, 1'b1);
        chk("simul_S_hold", S, 1'b0);
      end
      if (e == 5) begin
        chk("simul_I", I, 1'b0);
        chk("simul_S", S, 1'b1);
      end
      if (e >= 12) chk("persist_set", fault, (e >= 13));
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_persist", fault, 1'b0);
    for (int e = 15; e <= 21; e++) begin
      tick();
      chk("recount", fault, 1'b0);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_wins", fault, 1'b0);
    for (int e = 23; e <= 30; e++) begin
      tick();
      chk("reassert", fault, (e >= 30));
    end

    // Async reset while the I debounce count is 3
    I_raw = 1'b1;
    repeat (5) tick();
    #1 reset = 1'b1;
    #1;
    chk("async_I", I, 1'b1);
    chk("async_S", S, 1'b1);
    chk("async_fault", fault, 1'b0);
    chk("async_valid", valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    I_raw = 1'b0;
    tick();
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("post_rst_I", I, (e >= 5) ? 1'b0 : 1'b1);
      chk("post_rst_valid", valid, (e >= 5));
    end

    // Randomized phase, checked every cycle against the model
    hold_i = 0;
    hold_s = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (hold_i == 0) begin
        I_raw = 1'($urandom_range(0, 1));
        hold_i = $urandom_range(1, 12);
      end else hold_i--;
      if (hold_s == 0) begin
        S_raw = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 12);
      end else hold_s--;
      fault_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
